// File: rtl/sop_pipe_unit.sv
// sop_pipe_unit: two-stage valid/ready pipeline that evaluates a per-bit
// two-term logic function (SOP, POS, XOR-of-products, NOR-of-products)
// of four W-bit operands and reports the popcount of the result.
// Optional feature macro: SOP_PIPE_PARITY_EN adds a registered parity
// output 'par' (= ^s) that follows s exactly.
module sop_pipe_unit #(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic [W-1:0]           c,
    input  logic [W-1:0]           d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           s,
    output logic [$clog2(W+1)-1:0] ones
`ifdef SOP_PIPE_PARITY_EN
    ,
    output logic                   par
`endif
);

    localparam int OW = $clog2(W + 1);

    localparam logic [1:0] MODE_SOP  = 2'd0;
    localparam logic [1:0] MODE_POS  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_NSOP = 2'd3;

    // Number of set bits in a result word.
    function automatic logic [OW-1:0] popcount(input logic [W-1:0] v);
        logic [OW-1:0] n;
        n = {OW{1'b0}};
        for (int i = 0; i < W; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    // Even parity (XOR reduction) of a result word.
    function automatic logic parity(input logic [W-1:0] v);
        return ^v;
    endfunction

    // Stage 1 state: the two intermediate terms and the mode that combines them.
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_x_q,     s1_x_d;
    logic [W-1:0] s1_y_q,     s1_y_d;
    logic [1:0]   s1_mode_q,  s1_mode_d;

    // Stage 2 state: the visible result.
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  s_q,         s_d;
    logic [OW-1:0] ones_q,      ones_d;
    logic          par_q,       par_d;

    logic          s2_load;
    logic          in_xfer;
    logic [W-1:0]  comb_res;

    // S2 can take S1's word when it is empty or its word leaves this cycle;
    // in_ready is therefore combinational from out_ready so a full pipe still
    // streams at one word per cycle.
    assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign in_xfer  = in_valid & in_ready;

    // Stage 1 next state: capture product (or, for POS, sum) terms on accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_mode_d  = s1_mode_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = mode;
            if (mode == MODE_POS) begin
                s1_x_d = a | c;
                s1_y_d = b | d;
            end else begin
                s1_x_d = a & c;
                s1_y_d = b & d;
            end
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Combine the two registered terms according to the captured mode.
    always_comb begin
        comb_res = {W{1'b0}};
        case (s1_mode_q)
            MODE_SOP:  comb_res = s1_x_q | s1_y_q;
            MODE_POS:  comb_res = s1_x_q & s1_y_q;
            MODE_XOR:  comb_res = s1_x_q ^ s1_y_q;
            MODE_NSOP: comb_res = ~(s1_x_q | s1_y_q);
            default:   comb_res = {W{1'b0}};
        endcase
    end

    // Stage 2 next state: load from S1, retire on output transfer, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        s_d         = s_q;
        ones_d      = ones_q;
        par_d       = par_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            s_d         = comb_res;
            ones_d      = popcount(comb_res);
            par_d       = parity(comb_res);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers with synchronous reset that drops any in-flight words.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= {W{1'b0}};
            s1_y_q      <= {W{1'b0}};
            s1_mode_q   <= 2'd0;
            out_valid_q <= 1'b0;
            s_q         <= {W{1'b0}};
            ones_q      <= {OW{1'b0}};
            par_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            ones_q      <= ones_d;
            par_q       <= par_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign ones      = ones_q;
`ifdef SOP_PIPE_PARITY_EN
    assign par       = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_sop_pipe_unit.sv
// Scoreboard bench for sop_pipe_unit (W=4). Expected words are pushed on
// every input transfer and compared against the head on every cycle the
// output is valid; the head is popped on output transfer.
module tb_sop_pipe_unit;

    localparam int W  = 4;
    localparam int OW = $clog2(W + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [W-1:0]  a, b, c, d;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic [OW-1:0] ones;
`ifdef SOP_PIPE_PARITY_EN
    logic          par;
`endif

    sop_pipe_unit #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .ones     (ones)
`ifdef SOP_PIPE_PARITY_EN
        ,
        .par      (par)
`endif
    );

    typedef struct {
        logic [W-1:0] s;
        int           acc;
    } ent_t;

    ent_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b1;
    bit   fresh   = 1'b1;
    bit   post_rst = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] ta,
                                           input logic [W-1:0] tb_, input logic [W-1:0] tc,
                                           input logic [W-1:0] td);
        case (m)
            2'd0:    return (ta & tc) | (tb_ & td);
            2'd1:    return (ta | tc) & (tb_ | td);
            2'd2:    return (ta & tc) ^ (tb_ & td);
            default: return ~((ta & tc) | (tb_ & td));
        endcase
    endfunction

    // Per-cycle monitor: flow-control, output compare, pop, push.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                fresh    = 1'b1;
                post_rst = 1'b1;
            end else begin
                if (post_rst) begin
                    check_eq("rst_out_valid", out_valid, 0);
                    check_eq("rst_s", s, 0);
                    check_eq("rst_ones", ones, 0);
                    check_eq("rst_in_ready", in_ready, 1);
`ifdef SOP_PIPE_PARITY_EN
                    check_eq("rst_par", par, 0);
`endif
                    post_rst = 1'b0;
                end
                // Two words fit in the pipe; a full pipe accepts only if the
                // output word leaves this cycle.
                check_eq("in_ready", in_ready, (sb.size() < 2) || out_ready);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_out", out_valid, 0);
                    end else begin
                        check_eq("s", s, sb[0].s);
                        check_eq("ones", ones, $countones(sb[0].s));
`ifdef SOP_PIPE_PARITY_EN
                        check_eq("par", par, ^sb[0].s);
`endif
                        if (fresh && lat_chk)
                            check_eq("latency", cyc - sb[0].acc, 2);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                fresh = !out_valid || out_ready;
                if (in_valid && in_ready)
                    sb.push_back('{s: model(mode, a, b, c, d), acc: cyc});
            end
        end
    end

    // Present one operand set and hold it until accepted.
    task automatic send(input logic [1:0] m, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] tc, input logic [W-1:0] td, output int tries);
        bit got;
        in_valid = 1'b1;
        mode = m; a = ta; b = tb_; c = tc; d = td;
        tries = 0;
        got = 1'b0;
        while (!got && tries < 100) begin
            @(negedge clk);
            got = in_ready;
            tries++;
            @(posedge clk);
            #1;
        end
        if (!got) check_eq("accept_timeout", got, 1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mode = 2'd0; a = '0; b = '0; c = '0; d = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Mode 0 truth table, each operand all-zeros or all-ones.
        for (int k = 0; k < 16; k++)
            send(2'd0, {W{k[3]}}, {W{k[2]}}, {W{k[1]}}, {W{k[0]}}, t);
        drain();

        // Mode sweep on fixed operands.
        for (int m = 0; m < 4; m++)
            send(m[1:0], 4'b1010, 4'b0110, 4'b1100, 4'b0011, t);
        drain();

        // Backpressure: out_ready low for five cycles during a 5-word burst.
        lat_chk = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(2'(k), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), t);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Full throughput: every word accepted on first try.
        lat_chk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), t);
            check_eq("tp_accept_tries", t, 1);
        end
        drain();

        // Reset with both stages holding words.
        out_ready = 1'b0;
        send(2'd0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, t);
        send(2'd2, 4'b1010, 4'b0101, 4'b1111, 4'b1111, t);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        send(2'd1, 4'b0001, 4'b0010, 4'b0100, 4'b1000, t);
        drain();

        // Random traffic with random backpressure.
        lat_chk = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++)
                    send(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), t);
                in_valid = 1'b0;
            end
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Parity vectors (par compared by the monitor when enabled).
        lat_chk = 1'b1;
        send(2'd0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, t);
        send(2'd0, 4'b0111, 4'b0000, 4'b0111, 4'b0000, t);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
